// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable framing and glitch-rejecting start detection,
// feeding a first-word-fall-through receive FIFO with a valid/ready read port.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        uart_rx,
  output logic [DATA_BITS-1:0]        rd_data,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [$clog2(FIFO_DEPTH):0] rd_count,
  output logic                        frame_err,
  output logic                        parity_err,
  output logic                        overrun
);
  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW   = $clog2(DATA_BITS + 1);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned NW   = AW + 1;

  typedef enum logic [2:0] {
    S_WAIT_HIGH, S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_STOP2
  } state_t;

  state_t               state, state_d;
  logic                 sync1, rxs;
  logic [CW-1:0]        cnt, cnt_d;
  logic [BW-1:0]        bit_cnt, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic                 par_ok, par_ok_d;
  logic                 push_c, frame_c, perr_c;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [NW-1:0]        count;
  logic                 full_c, pop_c, wr_c;

  // Next-state logic; cnt free-runs and is cleared on every sample point.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt + CW'(1);
    bit_cnt_d = bit_cnt;
    shreg_d   = shreg;
    par_ok_d  = par_ok;
    push_c    = 1'b0;
    frame_c   = 1'b0;
    perr_c    = 1'b0;
    case (state)
      S_WAIT_HIGH: begin
        cnt_d = '0;
        if (rxs) state_d = S_IDLE;
      end
      S_IDLE: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
        if (!rxs) state_d = S_START;
      end
      S_START: begin
        if (cnt == CW'(HALF - 1)) begin
          cnt_d   = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d     = '0;
          shreg_d   = {rxs, shreg[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt + BW'(1);
          if (bit_cnt == BW'(DATA_BITS - 1)) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d    = '0;
          par_ok_d = (((^shreg) ^ rxs) == (PARITY == 2));
          state_d  = S_STOP;
        end
      end
      S_STOP, S_STOP2: begin
        if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d = '0;
          if (!rxs) begin
            frame_c = 1'b1;
            state_d = S_WAIT_HIGH;
          end else if (state == S_STOP && STOP_BITS == 2) begin
            state_d = S_STOP2;
          end else begin
            state_d = S_IDLE;
            if (PARITY != 0 && !par_ok) perr_c = 1'b1;
            else push_c = 1'b1;
          end
        end
      end
      default: state_d = S_WAIT_HIGH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= 1'b1;
      rxs        <= 1'b1;
      state      <= S_WAIT_HIGH;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_ok     <= 1'b1;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      sync1      <= uart_rx;
      rxs        <= sync1;
      state      <= state_d;
      cnt        <= cnt_d;
      bit_cnt    <= bit_cnt_d;
      shreg      <= shreg_d;
      par_ok     <= par_ok_d;
      frame_err  <= frame_c;
      parity_err <= perr_c;
    end
  end

  // A pop on the same edge frees the slot, so a push while full is then accepted.
  assign full_c = (count == NW'(FIFO_DEPTH));
  assign pop_c  = rd_valid && rd_ready;
  assign wr_c   = push_c && (!full_c || pop_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem     <= '{default: '0};
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_c) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + AW'(1);
      count   <= count + NW'(wr_c) - NW'(pop_c);
      overrun <= push_c && full_c && !pop_c;
    end
  end

  assign rd_valid = (count != '0);
  assign rd_count = count;
  assign rd_data  = mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: default 8N1, even-parity and depth-4 instances.
module tb_uart_rx_fifo;
  localparam int unsigned CPB = 8;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] tx;
  logic [2:0] rdy;

  logic [7:0] data0, data1, data2;
  logic       v0, v1, v2;
  logic [3:0] cnt0, cnt1;
  logic [2:0] cnt2;
  logic       fe0, fe1, fe2, pe0, pe1, pe2, ov0, ov1, ov2;

  int fe_n [3] = '{0, 0, 0};
  int pe_n [3] = '{0, 0, 0};
  int ov_n [3] = '{0, 0, 0};
  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  uart_rx_fifo u0 (
    .clk(clk), .rst(rst), .uart_rx(tx[0]), .rd_data(data0), .rd_valid(v0), .rd_ready(rdy[0]),
    .rd_count(cnt0), .frame_err(fe0), .parity_err(pe0), .overrun(ov0));

  uart_rx_fifo #(.PARITY(1)) u1 (
    .clk(clk), .rst(rst), .uart_rx(tx[1]), .rd_data(data1), .rd_valid(v1), .rd_ready(rdy[1]),
    .rd_count(cnt1), .frame_err(fe1), .parity_err(pe1), .overrun(ov1));

  uart_rx_fifo #(.FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst(rst), .uart_rx(tx[2]), .rd_data(data2), .rd_valid(v2), .rd_ready(rdy[2]),
    .rd_count(cnt2), .frame_err(fe2), .parity_err(pe2), .overrun(ov2));

  // Pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (fe0) fe_n[0]++;
    if (fe1) fe_n[1]++;
    if (fe2) fe_n[2]++;
    if (pe0) pe_n[0]++;
    if (pe1) pe_n[1]++;
    if (pe2) pe_n[2]++;
    if (ov0) ov_n[0]++;
    if (ov1) ov_n[1]++;
    if (ov2) ov_n[2]++;
  end

  // Called at a negedge; drives start, 8 data bits LSB first, optional parity, stop.
  task automatic send_frame(input int sel, input logic [7:0] d, input bit use_par,
                            input bit par, input bit stop);
    tx[sel] = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      tx[sel] = d[i];
      repeat (CPB) @(negedge clk);
    end
    if (use_par) begin
      tx[sel] = par;
      repeat (CPB) @(negedge clk);
    end
    tx[sel] = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic pop_one(input int sel);
    rdy[sel] = 1'b1;
    @(negedge clk);
    rdy[sel] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (v0 !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", v0); end
    checks++; if (cnt0 !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", cnt0); end
    checks++; if (data0 !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", data0); end
    checks++; if ({fe0, pe0, ov0} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b expected 000", {fe0, pe0, ov0}); end
    checks++; if (cnt2 !== 3'd0) begin fails++; $display("FAIL reset_count_d4: got %0d expected 0", cnt2); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    int fb, pb, ob;
    fb = fe_n[0]; pb = pe_n[0]; ob = ov_n[0];
    fork
      send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
      begin
        repeat (78) @(posedge clk);
        #1;
        checks++; if (v0 !== 1'b0) begin fails++; $display("FAIL basic_valid_edge77: got %b expected 0", v0); end
        @(posedge clk);
        #1;
        checks++; if (v0 !== 1'b1) begin fails++; $display("FAIL basic_valid_edge78: got %b expected 1", v0); end
        checks++; if (data0 !== 8'hA5) begin fails++; $display("FAIL basic_data: got %h expected a5", data0); end
        checks++; if (cnt0 !== 4'd1) begin fails++; $display("FAIL basic_count: got %0d expected 1", cnt0); end
      end
    join
    checks++; if ((fe_n[0] - fb) + (pe_n[0] - pb) + (ov_n[0] - ob) !== 0) begin fails++; $display("FAIL basic_no_errors: got %0d pulses expected 0", (fe_n[0] - fb) + (pe_n[0] - pb) + (ov_n[0] - ob)); end
    pop_one(0);
    checks++; if (v0 !== 1'b0) begin fails++; $display("FAIL basic_pop_valid: got %b expected 0", v0); end
    checks++; if (cnt0 !== 4'd0) begin fails++; $display("FAIL basic_pop_count: got %0d expected 0", cnt0); end
  endtask

  task automatic test_glitch();
    int fb, pb;
    fb = fe_n[0]; pb = pe_n[0];
    tx[0] = 1'b0;
    repeat (3) @(negedge clk);
    tx[0] = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (v0 !== 1'b0) begin fails++; $display("FAIL glitch_valid: got %b expected 0", v0); end
    checks++; if ((fe_n[0] - fb) + (pe_n[0] - pb) !== 0) begin fails++; $display("FAIL glitch_flags: got %0d pulses expected 0", (fe_n[0] - fb) + (pe_n[0] - pb)); end
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    checks++; if (data0 !== 8'h5A) begin fails++; $display("FAIL glitch_after_data: got %h expected 5a", data0); end
    checks++; if (cnt0 !== 4'd1) begin fails++; $display("FAIL glitch_after_count: got %0d expected 1", cnt0); end
    pop_one(0);
  endtask

  task automatic test_parity();
    int fb, pb;
    fb = fe_n[1]; pb = pe_n[1];
    send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1);
    checks++; if (pe_n[1] - pb !== 1) begin fails++; $display("FAIL parity_bad_pulse: got %0d expected 1", pe_n[1] - pb); end
    checks++; if (v1 !== 1'b0) begin fails++; $display("FAIL parity_bad_valid: got %b expected 0", v1); end
    send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1);
    checks++; if (v1 !== 1'b1) begin fails++; $display("FAIL parity_good_valid: got %b expected 1", v1); end
    checks++; if (data1 !== 8'h03) begin fails++; $display("FAIL parity_good_data: got %h expected 03", data1); end
    checks++; if (pe_n[1] - pb !== 1) begin fails++; $display("FAIL parity_good_no_pulse: got %0d expected 1", pe_n[1] - pb); end
    pop_one(1);
    // bad parity together with a low stop bit
    send_frame(1, 8'h03, 1'b1, 1'b1, 1'b0);
    tx[1] = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (fe_n[1] - fb !== 1) begin fails++; $display("FAIL parity_prec_frame: got %0d expected 1", fe_n[1] - fb); end
    checks++; if (pe_n[1] - pb !== 1) begin fails++; $display("FAIL parity_prec_parity: got %0d expected 1", pe_n[1] - pb); end
    checks++; if (cnt1 !== 4'd0) begin fails++; $display("FAIL parity_prec_count: got %0d expected 0", cnt1); end
  endtask

  task automatic test_frame();
    int fb;
    fb = fe_n[0];
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    checks++; if (fe_n[0] - fb !== 1) begin fails++; $display("FAIL frame_pulse: got %0d expected 1", fe_n[0] - fb); end
    checks++; if (cnt0 !== 4'd0) begin fails++; $display("FAIL frame_low_count: got %0d expected 0", cnt0); end
    tx[0] = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    checks++; if (data0 !== 8'h11) begin fails++; $display("FAIL frame_next_data: got %h expected 11", data0); end
    checks++; if (cnt0 !== 4'd1) begin fails++; $display("FAIL frame_next_count: got %0d expected 1", cnt0); end
    checks++; if (fe_n[0] - fb !== 1) begin fails++; $display("FAIL frame_single: got %0d expected 1", fe_n[0] - fb); end
  endtask

  task automatic test_reset_midframe();
    int fb, pb;
    fork
      send_frame(0, 8'hF0, 1'b0, 1'b0, 1'b1);
      begin
        repeat (CPB * 5 + 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (v0 !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b expected 0", v0); end
        checks++; if (cnt0 !== 4'd0) begin fails++; $display("FAIL midrst_count: got %0d expected 0", cnt0); end
        checks++; if (data0 !== 8'h00) begin fails++; $display("FAIL midrst_data: got %h expected 00", data0); end
      end
    join
    repeat (4) @(negedge clk);
    checks++; if (cnt0 !== 4'd0) begin fails++; $display("FAIL midrst_ignored: got %0d expected 0", cnt0); end
    fb = fe_n[0]; pb = pe_n[0];
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    checks++; if (data0 !== 8'h3C) begin fails++; $display("FAIL midrst_next_data: got %h expected 3c", data0); end
    checks++; if (cnt0 !== 4'd1) begin fails++; $display("FAIL midrst_next_count: got %0d expected 1", cnt0); end
    checks++; if ((fe_n[0] - fb) + (pe_n[0] - pb) !== 0) begin fails++; $display("FAIL midrst_next_flags: got %0d expected 0", (fe_n[0] - fb) + (pe_n[0] - pb)); end
    pop_one(0);
  endtask

  task automatic test_back_to_back_overrun();
    int ob;
    ob = ov_n[2];
    for (int k = 1; k <= 4; k++) send_frame(2, 8'(k), 1'b0, 1'b0, 1'b1);
    checks++; if (cnt2 !== 3'd4) begin fails++; $display("FAIL ovr_fill_count: got %0d expected 4", cnt2); end
    checks++; if (ov_n[2] - ob !== 0) begin fails++; $display("FAIL ovr_fill_pulse: got %0d expected 0", ov_n[2] - ob); end
    send_frame(2, 8'h05, 1'b0, 1'b0, 1'b1);
    checks++; if (cnt2 !== 3'd4) begin fails++; $display("FAIL ovr_full_count: got %0d expected 4", cnt2); end
    checks++; if (ov_n[2] - ob !== 1) begin fails++; $display("FAIL ovr_pulse: got %0d expected 1", ov_n[2] - ob); end
    for (int k = 1; k <= 4; k++) begin
      checks++; if (data2 !== 8'(k)) begin fails++; $display("FAIL ovr_drain_%0d: got %h expected %h", k, data2, 8'(k)); end
      pop_one(2);
    end
    checks++; if (v2 !== 1'b0) begin fails++; $display("FAIL ovr_empty_valid: got %b expected 0", v2); end
    pop_one(2);
    checks++; if (cnt2 !== 3'd0) begin fails++; $display("FAIL ovr_pop_empty: got %0d expected 0", cnt2); end
  endtask

  task automatic test_full_push_pop();
    int ob;
    for (int k = 1; k <= 4; k++) send_frame(2, 8'(8'h20 + k), 1'b0, 1'b0, 1'b1);
    ob = ov_n[2];
    fork
      send_frame(2, 8'h25, 1'b0, 1'b0, 1'b1);
      begin
        repeat (78) @(negedge clk);
        rdy[2] = 1'b1;
        @(negedge clk);
        rdy[2] = 1'b0;
      end
    join
    checks++; if (cnt2 !== 3'd4) begin fails++; $display("FAIL fpp_count: got %0d expected 4", cnt2); end
    checks++; if (ov_n[2] - ob !== 0) begin fails++; $display("FAIL fpp_no_overrun: got %0d expected 0", ov_n[2] - ob); end
    for (int k = 2; k <= 5; k++) begin
      checks++; if (data2 !== 8'(8'h20 + k)) begin fails++; $display("FAIL fpp_drain_%0d: got %h expected %h", k, data2, 8'(8'h20 + k)); end
      pop_one(2);
    end
    checks++; if (v2 !== 1'b0) begin fails++; $display("FAIL fpp_empty: got %b expected 0", v2); end
  endtask

  initial begin
    tx  = 3'b111;
    rdy = 3'b000;
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_parity();
    test_frame();
    test_reset_midframe();
    test_back_to_back_overrun();
    test_full_push_pop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end
endmodule
